// File: rtl/regfile_pkg.sv
// Shared sizing constants and word/address types for the register file.
package regfile_pkg;

  localparam int unsigned REG_WIDTH  = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ZERO_REG   = 31;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_word.sv
// One storage word of the register file: loads d when load is high.
module regfile_word #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset clears the word; otherwise load captures new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_read_stage.sv
// Decode/register-read stage: 1 write port, 2 registered read ports with
// write-through bypass, stall hold, flush and a hardwired zero register.
module regfile_read_stage
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = regfile_pkg::REG_WIDTH,
  parameter int unsigned NREGS    = regfile_pkg::REG_COUNT,
  parameter int unsigned ADDR_W   = regfile_pkg::REG_ADDR_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_tag1,
  output logic [ADDR_W-1:0] rd_tag2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] mem [NREGS];
  logic [WIDTH-1:0] next_data1;
  logic [WIDTH-1:0] next_data2;

  // Storage: one word per register except the zero register, which is a
  // constant so neither writes nor bypass can ever make it non-zero.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_word
      logic load;
      assign load = wr_en && (wr_addr == ADDR_W'(i));
      regfile_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (wr_data),
        .q     (mem[i])
      );
    end
  end

  // Operand selection: zero register first, then same-cycle write bypass,
  // then stored contents.
  always_comb begin
    next_data1 = '0;
    next_data2 = '0;
    if (rd_addr1 != ZERO_ADDR) begin
      next_data1 = (wr_en && (wr_addr == rd_addr1)) ? wr_data : mem[rd_addr1];
    end
    if (rd_addr2 != ZERO_ADDR) begin
      next_data2 = (wr_en && (wr_addr == rd_addr2)) ? wr_data : mem[rd_addr2];
    end
  end

  // Output registers: reset and flush clear the slot, rd_en advances it,
  // otherwise (stall) everything holds without refreshing from later writes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_tag1  <= '0;
      rd_tag2  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data1 <= next_data1;
      rd_data2 <= next_data2;
      rd_tag1  <= rd_addr1;
      rd_tag2  <= rd_addr2;
      rd_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: a directed vector table with hand-derived
// expectations, then a random phase checked against a behavioural model.
// Expectations are queued when stimulus is driven and popped after the edge.
module tb_regfile_read_stage;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      reset, wr_en, rd_en, flush;
  reg_addr_t wr_addr, rd_addr1, rd_addr2;
  reg_word_t wr_data;
  reg_word_t rd_data1, rd_data2;
  logic      rd_valid;
  reg_addr_t rd_tag1, rd_tag2;

  regfile_read_stage dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .flush    (flush),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .rd_valid (rd_valid),
    .rd_tag1  (rd_tag1),
    .rd_tag2  (rd_tag2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic      rst, we;
    reg_addr_t wa;
    reg_word_t wd;
    logic      re, fl;
    reg_addr_t a1, a2;
    logic      ev;
    reg_word_t e1, e2;
    reg_addr_t t1, t2;
  } vec_t;

  typedef struct {
    int        id;
    logic      ev;
    reg_word_t e1, e2;
    reg_addr_t t1, t2;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  // Behavioural model for the random phase.
  reg_word_t m_mem [32];
  reg_word_t m_d1, m_d2;
  reg_addr_t m_t1, m_t2;
  logic      m_v;

  function automatic reg_word_t m_read(reg_addr_t a, logic we, reg_addr_t wa, reg_word_t wd);
    if (a == 5'd31) return '0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    rd_en = v.re;  flush = v.fl; rd_addr1 = v.a1; rd_addr2 = v.a2;
  endtask

  task automatic check_one;
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expectation, required one queued");
      return;
    end
    e = exp_q.pop_front();
    if (rd_valid !== e.ev || rd_data1 !== e.e1 || rd_data2 !== e.e2 ||
        rd_tag1 !== e.t1 || rd_tag2 !== e.t2) begin
      errors++;
      $display("FAIL step%0d: got v=%0b d1=%h d2=%h t1=%0d t2=%0d, required v=%0b d1=%h d2=%h t1=%0d t2=%0d",
               e.id, rd_valid, rd_data1, rd_data2, rd_tag1, rd_tag2,
               e.ev, e.e1, e.e2, e.t1, e.t2);
    end
  endtask

  // Drive on the falling edge, queue the expectation, check 1 after the rise.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.id = id; e.ev = v.ev; e.e1 = v.e1; e.e2 = v.e2; e.t1 = v.t1; e.t2 = v.t2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  function automatic vec_t mk(logic rst, logic we, reg_addr_t wa, reg_word_t wd,
                              logic re, logic fl, reg_addr_t a1, reg_addr_t a2,
                              logic ev, reg_word_t e1, reg_word_t e2,
                              reg_addr_t t1, reg_addr_t t2);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.fl = fl;
    v.a1 = a1; v.a2 = a2; v.ev = ev; v.e1 = e1; v.e2 = e2; v.t1 = t1; v.t2 = t2;
    return v;
  endfunction

  localparam reg_word_t K = 64'h0123_4567_89AB_CDEF;

  vec_t tbl[$];

  initial begin
    vec_t v;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //             rst we wa  wd       re fl a1  a2   ev e1     e2     t1  t2
    tbl.push_back(mk(1, 1, 3, 64'hFF,   1, 0, 3,  0,   0, 0,     0,     0,  0));
    tbl.push_back(mk(1, 1, 3, 64'hFF,   1, 0, 3,  0,   0, 0,     0,     0,  0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 3,  0,   1, 0,     0,     3,  0));
    tbl.push_back(mk(0, 1, 5, K,        0, 0, 0,  0,   1, 0,     0,     3,  0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 5,  3,   1, K,     0,     5,  3));
    tbl.push_back(mk(0, 1, 31, 64'hDEAD,1, 0, 31, 31,  1, 0,     0,     31, 31));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 31, 5,   1, 0,     K,     31, 5));
    tbl.push_back(mk(0, 1, 7, 64'h11,   1, 0, 0,  0,   1, 0,     0,     0,  0));
    tbl.push_back(mk(0, 1, 7, 64'h22,   1, 0, 7,  7,   1, 64'h22,64'h22,7,  7));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 7,  31,  1, 64'h22,0,     7,  31));
    tbl.push_back(mk(0, 1, 4, 64'hAA,   0, 0, 0,  0,   1, 64'h22,0,     7,  31));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 4,  7,   1, 64'hAA,64'h22,4,  7));
    tbl.push_back(mk(0, 1, 4, 64'hBB,   0, 0, 4,  4,   1, 64'hAA,64'h22,4,  7));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0, 4,  4,   1, 64'hAA,64'h22,4,  7));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0, 4,  4,   1, 64'hAA,64'h22,4,  7));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 4,  4,   1, 64'hBB,64'hBB,4,  4));
    tbl.push_back(mk(0, 1, 9, 64'h5,    1, 1, 9,  9,   0, 0,     0,     0,  0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 9,  4,   1, 64'h5, 64'hBB,9,  4));
    tbl.push_back(mk(0, 0, 0, 0,        0, 1, 9,  4,   0, 0,     0,     0,  0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 9,  9,   1, 64'h5, 64'h5, 9,  9));
    tbl.push_back(mk(1, 1, 9, 64'h7,    1, 0, 9,  9,   0, 0,     0,     0,  0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 9,  5,   1, 0,     0,     9,  5));
    tbl.push_back(mk(0, 1, 5, 64'h77,   1, 0, 9,  5,   1, 0,     64'h77,9,  5));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, 5,  4,   1, 64'h77,0,     5,  4));

    foreach (tbl[i]) apply(tbl[i], i);

    // Random phase: starts with a reset so the model and DUT agree.
    foreach (m_mem[i]) m_mem[i] = '0;
    m_d1 = '0; m_d2 = '0; m_t1 = '0; m_t2 = '0; m_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reg_word_t nd1, nd2;
      v.rst = (n == 0) || ($urandom_range(0, 39) == 0);
      v.we  = $urandom_range(0, 1) == 1;
      v.wa  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      v.wd  = {$urandom, $urandom};
      v.re  = $urandom_range(0, 3) != 0;
      v.fl  = $urandom_range(0, 7) == 0;
      v.a1  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      v.a2  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      nd1 = m_read(v.a1, v.we, v.wa, v.wd);
      nd2 = m_read(v.a2, v.we, v.wa, v.wd);
      if (v.rst) begin
        foreach (m_mem[i]) m_mem[i] = '0;
      end else if (v.we && v.wa != 5'd31) begin
        m_mem[v.wa] = v.wd;
      end
      if (v.rst || v.fl) begin
        m_d1 = '0; m_d2 = '0; m_t1 = '0; m_t2 = '0; m_v = 1'b0;
      end else if (v.re) begin
        m_d1 = nd1; m_d2 = nd2; m_t1 = v.a1; m_t2 = v.a2; m_v = 1'b1;
      end
      v.ev = m_v; v.e1 = m_d1; v.e2 = m_d2; v.t1 = m_t1; v.t2 = m_t2;
      apply(v, 1000 + n);
    end

    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Register file with 1 write port and 2 registered read ports, built for the pipelined datapath's decode/register-read stage.
- Write side stores a word on the clock edge when enabled.
- Read side samples two addresses and returns operands one cycle later, with write-through bypass, stall hold and flush.
- Register 31 is the hardwired zero register.

Parameters:
- WIDTH, 64, data word width in bits
- NREGS, 32, number of architectural registers
- ADDR_W, 5, register address width; NREGS == 2**ADDR_W
- ZERO_REG, 31, index that always reads 0 and ignores writes

Ports:
- clk  input  1  single system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset, sampled on posedge clk
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write register index
- wr_data  input  WIDTH  write data
- rd_en  input  1  read advance; 0 = stall, outputs hold
- flush  input  1  squash the read slot
- rd_addr1  input  ADDR_W  read port 1 index
- rd_addr2  input  ADDR_W  read port 2 index
- rd_data1  output  WIDTH  port 1 operand, registered
- rd_data2  output  WIDTH  port 2 operand, registered
- rd_valid  output  1  operands in rd_data1/2 are live
- rd_tag1  output  ADDR_W  address that produced rd_data1
- rd_tag2  output  ADDR_W  address that produced rd_data2

Behaviour:
- Reset (synchronous, active-high): all NREGS words <= 0; rd_data1/2 <= 0; rd_tag1/2 <= 0; rd_valid <= 0. Reset overrides wr_en, rd_en and flush in the same cycle.
- Write: at posedge, if wr_en && !reset && wr_addr != ZERO_REG, then mem[wr_addr] <= wr_data. Otherwise every word holds its value.
- ZERO_REG: storage is never written, and reads always return 0, including under bypass.
- Read latency: 1 cycle. Addresses are sampled at posedge N; data is visible after posedge N until the next update.
- Read update at posedge, when rd_en && !flush:
  - rd_dataK <= (rd_addrK == ZERO_REG) ? 0 : (wr_en && wr_addr == rd_addrK) ? wr_data : mem[rd_addrK]
  - rd_tagK <= rd_addrK
  - rd_valid <= 1
- Bypass: a same-cycle write to the read address returns the new data, never stale data. This applies to each port independently; both ports may bypass the same write.
- Stall (rd_en=0, flush=0):
  - rd_data1/2, rd_tag1/2 and rd_valid hold.
  - Held data is NOT refreshed by later writes to the same index. The consumer resolves that hazard through rd_tagK.
- Flush (flush=1): rd_valid <= 0, rd_data1/2 <= 0, rd_tag1/2 <= 0. Flush wins over rd_en. The write still completes in the same cycle.
- Address range: all ADDR_W-bit values are legal, so there is no out-of-range case.
- No combinational path from any input to any output.

Decomposition:
- Package regfile_pkg:
  - constants REG_WIDTH=64, REG_ADDR_W=5, REG_COUNT=32, ZERO_REG=31
  - typedef reg_word_t (logic [REG_WIDTH-1:0])
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0])
- Sub-module regfile_word: one WIDTH-bit storage word with load enable, clk and synchronous reset.
  - Instantiated NREGS-1 times; ZERO_REG has no storage.
  - Write decode: wr_addr one-hot ANDed with wr_en drives each word's enable.
- Read muxes, bypass compare and output registers live in the top level.

Test Plan:
- Reset, then read: assert reset for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xFF. Then read addr1=3 and addr2=0 with rd_en=1 → next cycle rd_data1=0, rd_data2=0, rd_valid=1, rd_tag1=3.
- Write then read: write 0x0123_4567_89AB_CDEF to x5. Next cycle read addr1=5 → following cycle rd_data1=0x0123456789ABCDEF.
- Zero register: write 0xDEAD to x31 with a same-cycle read of addr1=31 and addr2=31 → rd_data1=rd_data2=0. A later read of x31 → still 0.
- Bypass: x7=0x11. Same cycle, write x7<=0x22 and read addr1=7, addr2=7 → next cycle both read 0x22. A following read of x7 → 0x22.
- Stall: read x4=0xAA (valid). Then hold rd_en=0 for 3 cycles while writing x4<=0xBB → rd_data1 stays 0xAA and rd_valid stays 1. Raise rd_en → 0xBB.
- Flush and reset mid-operation:
  - rd_en=1 and flush=1 with a write x9<=0x5 → rd_valid=0 and rd_data=0. Next read of x9 → 0x5.
  - Assert reset while rd_valid=1 → rd_valid=0 and x9 reads 0 afterwards.
